// File: rtl/freq_div_ctrl.sv
// Run-time controller for clock-enable frequency dividers: divisor handshake,
// start/stop FSM, and period-boundary ratio updates so no runt period is emitted.
module freq_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             busy,
  output logic             div_out,
  output logic             tick,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend_v;
  logic             r_cfg_err;

  logic [WIDTH-1:0] w_last;
  logic [WIDTH:0]   w_half;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_busy;
  logic             w_wrap;
  logic             w_go;
  logic             w_xfer;
  logic             w_div_ok;

  assign w_busy    = (r_state != S_IDLE);
  assign w_last    = r_cur_div - WIDTH'(1);
  assign w_wrap    = (r_cnt == w_last);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + WIDTH'(1);
  // Extra bit keeps (N+1)/2 exact when N is the largest WIDTH-bit value.
  assign w_half    = ({1'b0, r_cur_div} + (WIDTH+1)'(1)) >> 1;
  assign w_go      = start & ~stop;
  assign w_xfer    = cfg_valid & ~r_pend_v;
  assign w_div_ok  = (cfg_div >= WIDTH'(2));

  assign busy      = w_busy;
  assign cfg_ready = ~r_pend_v;
  assign div_out   = w_busy & ({1'b0, r_cnt} >= w_half);
  assign tick      = w_busy & w_wrap;
  assign cfg_err   = r_cfg_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur_div  <= WIDTH'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_pend_v   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer & ~w_div_ok;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_go) r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          if (stop) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_cnt <= w_cnt_nxt;
          if (w_go)        r_state <= S_RUN;
          else if (w_wrap) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      // Idle has no period to protect, so a divisor lands (or a leftover
      // pending one drains) immediately; while counting it waits for the wrap.
      if (r_state == S_IDLE) begin
        if (r_pend_v) begin
          r_cur_div <= r_pend_div;
          r_pend_v  <= 1'b0;
        end else if (w_xfer && w_div_ok) begin
          r_cur_div <= cfg_div;
        end
      end else begin
        if (w_wrap && r_pend_v) begin
          r_cur_div <= r_pend_div;
          r_pend_v  <= 1'b0;
        end
        if (w_xfer && w_div_ok) begin
          r_pend_div <= cfg_div;
          r_pend_v   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: per-cycle expected outputs are queued
// as stimulus is driven and compared one cycle later via immediate assertions.
module tb_freq_div_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             busy;
  logic             div_out;
  logic             tick;
  logic             cfg_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [4:0] v;   // {div_out, tick, busy, cfg_ready, cfg_err}
  } exp_t;

  exp_t sb[$];

  freq_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .div_out   (div_out),
    .tick      (tick),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {div_out, tick, busy, cfg_ready, cfg_err};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Queue the expectation for the state after the next edge, then compare.
  task automatic cyc(input string tag, input logic [4:0] e);
    exp_t x;
    exp_t y;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      y = sb.pop_front();
      check(y.tag, obs(), y.v);
    end
  endtask

  // Running cycles at divisor n, starting at counter phase ph0.
  task automatic run(input string tag, input int n, input int ph0, input int cnt, input logic rdy);
    for (int i = 0; i < cnt; i++) begin
      int p;
      logic d;
      logic t;
      p = (ph0 + i) % n;
      d = (p >= (n + 1) / 2);
      t = (p == n - 1);
      cyc(tag, {d, t, 1'b1, rdy, 1'b0});
    end
  endtask

  localparam logic [4:0] IDLE_E = 5'b00010;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    #3;
    check("reset_vals", obs(), IDLE_E);
    cyc("reset_hold", IDLE_E);
    rst = 1'b0;
    cyc("idle", IDLE_E);

    // Rejected divisors while idle
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cyc("idle_rej1", 5'b00011);
    cfg_div = 8'd0;
    cyc("idle_rej0", 5'b00011);
    cfg_valid = 1'b0;
    cyc("idle_rej_clr", IDLE_E);

    // Default N=10 waveform
    start = 1'b1;
    run("n10_start", 10, 0, 1, 1'b1);
    start = 1'b0;
    run("n10", 10, 1, 29, 1'b1);

    // Rejected divisors while running
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cyc("run_rej1", 5'b00111);
    cfg_div = 8'd0;
    cyc("run_rej0", 5'b00111);
    cfg_valid = 1'b0;
    run("run_rej_clr", 10, 2, 2, 1'b1);

    // Offer N=4 at cnt=3; current period finishes at 10
    cfg_valid = 1'b1; cfg_div = 8'd4;
    run("pend4", 10, 4, 1, 1'b0);
    cfg_valid = 1'b0;
    run("pend4_hold", 10, 5, 5, 1'b0);
    run("n4", 4, 0, 12, 1'b1);

    // Transfer on the wrap edge applies one period later
    cfg_valid = 1'b1; cfg_div = 8'd10;
    run("wrap_xfer", 4, 0, 1, 1'b0);
    cfg_valid = 1'b0;
    run("wrap_xfer_hold", 4, 1, 3, 1'b0);
    run("n10b", 10, 0, 3, 1'b1);

    // Stop at cnt=2: drain to end of period
    stop = 1'b1;
    run("drain", 10, 3, 1, 1'b1);
    stop = 1'b0;
    run("drain_cont", 10, 4, 6, 1'b1);
    cyc("drain_idle", IDLE_E);
    cyc("drain_idle2", IDLE_E);

    // Stop then restart from DRAIN at cnt=6
    start = 1'b1;
    run("rs_start", 10, 0, 1, 1'b1);
    start = 1'b0;
    run("rs_run", 10, 1, 2, 1'b1);
    stop = 1'b1;
    run("rs_stop", 10, 3, 1, 1'b1);
    stop = 1'b0;
    run("rs_drain", 10, 4, 3, 1'b1);
    start = 1'b1;
    run("rs_resume", 10, 7, 1, 1'b1);
    start = 1'b0;
    run("rs_cont", 10, 8, 4, 1'b1);
    stop = 1'b1;
    run("rs_stop2", 10, 2, 1, 1'b1);
    stop = 1'b0;
    run("rs_drain2", 10, 3, 7, 1'b1);
    cyc("rs_idle", IDLE_E);

    // start and stop together in idle
    start = 1'b1; stop = 1'b1;
    cyc("both_idle", IDLE_E);
    cyc("both_idle2", IDLE_E);
    start = 1'b0; stop = 1'b0;

    // N=7 loaded directly in idle
    cfg_valid = 1'b1; cfg_div = 8'd7;
    cyc("cfg7_idle", IDLE_E);
    cfg_valid = 1'b0;
    start = 1'b1;
    run("n7_start", 7, 0, 1, 1'b1);
    start = 1'b0;
    run("n7", 7, 1, 9, 1'b1);
    cfg_valid = 1'b1; cfg_div = 8'd2;
    run("pend2", 7, 10, 1, 1'b0);
    cfg_valid = 1'b0;
    run("pend2_hold", 7, 11, 3, 1'b0);
    run("n2", 2, 0, 7, 1'b1);
    stop = 1'b1;
    run("n2_stop", 2, 7, 1, 1'b1);
    stop = 1'b0;
    cyc("n2_idle", IDLE_E);

    // Async reset mid-period with N=4 pending
    start = 1'b1;
    run("ar_start", 2, 0, 1, 1'b1);
    start = 1'b0;
    cfg_valid = 1'b1; cfg_div = 8'd4;
    run("ar_pend", 2, 1, 1, 1'b0);
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", obs(), IDLE_E);
    cyc("rst_hold", IDLE_E);
    rst = 1'b0;
    cyc("rst_idle", IDLE_E);
    start = 1'b1;
    run("post_rst", 10, 0, 1, 1'b1);
    start = 1'b0;
    run("post_rst_n10", 10, 1, 10, 1'b1);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
